rs_branch: RTL and testbench



---
 rtl/rs_branch.sv | 159 +++++++++++++++
 tb/tb_rs_branch.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_branch.sv
// rs_branch: reservation station for branch/jump micro-ops.
// Entries are kept in an age-ordered compacting queue (slot 0 oldest), wake up
// by snooping the CDB, and the oldest ready entry issues to the branch unit as
// a registered packet each cycle.
module rs_branch #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         dispatch_valid,
  output logic         dispatch_ready,
  input  logic [9:0]   dispatch_inst,
  input  logic [5:0]   dispatch_dest,
  input  logic [5:0]   dispatch_tag1,
  input  logic [5:0]   dispatch_tag2,
  input  logic [31:0]  dispatch_opr1,
  input  logic [31:0]  dispatch_opr2,
  input  logic [31:0]  dispatch_addr,
  input  logic [37:0]  cdb,
  output logic         en,
  output logic [111:0] rs2exe
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [9:0]  inst;
    logic [5:0]  dest;
    logic [5:0]  tag1;
    logic [31:0] opr1;
    logic [5:0]  tag2;
    logic [31:0] opr2;
    logic [31:0] addr;
  } entry_t;

  entry_t           ent_q     [DEPTH];
  entry_t           ent_d     [DEPTH];
  entry_t           shift_src [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             en_q;
  logic [111:0]     rs2exe_q;
  logic [DEPTH-1:0] ready_vec;
  logic [IW-1:0]    sel;
  logic             any_ready;
  logic             issue;
  logic             accept;
  logic [CW-1:0]    wr_idx;
  logic [111:0]     issue_pkt;
  entry_t           disp_ent;
  entry_t           disp_woken;
  logic [5:0]       cdb_tag;
  logic [31:0]      cdb_val;

  // A broadcast with a nonzero matching tag replaces the operand and clears the tag.
  function automatic entry_t wakeup(input entry_t e, input logic [5:0] t, input logic [31:0] v);
    entry_t r;
    r = e;
    if ((t != 6'd0) && (r.tag1 == t)) begin
      r.tag1 = 6'd0;
      r.opr1 = v;
    end
    if ((t != 6'd0) && (r.tag2 == t)) begin
      r.tag2 = 6'd0;
      r.opr2 = v;
    end
    return r;
  endfunction

  assign cdb_tag = cdb[37:32];
  assign cdb_val = cdb[31:0];

  assign disp_ent = {dispatch_inst, dispatch_dest, dispatch_tag1, dispatch_opr1,
                     dispatch_tag2, dispatch_opr2, dispatch_addr};
  // Incoming operands see the same-cycle broadcast so it is not lost.
  assign disp_woken = wakeup(disp_ent, cdb_tag, cdb_val);

  // Space is judged from the registered count only; a same-cycle issue does not help.
  assign dispatch_ready = (count_q < CW'(DEPTH)) && !flush;
  assign accept         = dispatch_valid && dispatch_ready;
  assign issue          = any_ready && !flush;
  assign wr_idx         = count_q - CW'(issue);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign ready_vec[gi] = (CW'(gi) < count_q) && (ent_q[gi].tag1 == 6'd0)
                           && (ent_q[gi].tag2 == 6'd0);
    // Source for a slot when the queue compacts: the next younger slot.
    if (gi < DEPTH - 1) begin : g_mid
      assign shift_src[gi] = ent_q[gi + 1];
    end else begin : g_top
      assign shift_src[gi] = ent_q[gi];
    end
  end

  // Lowest-index ready entry wins (oldest first).
  always_comb begin
    sel       = '0;
    any_ready = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        sel       = IW'(i);
        any_ready = 1'b1;
      end
    end
  end

  assign issue_pkt = {ent_q[sel].inst, ent_q[sel].dest, ent_q[sel].opr1,
                      ent_q[sel].opr2, ent_q[sel].addr};

  // Next entry contents: compact past the issued slot, wake up, then append dispatch.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (issue && (IW'(i) >= sel)) begin
        ent_d[i] = wakeup(shift_src[i], cdb_tag, cdb_val);
      end else begin
        ent_d[i] = wakeup(ent_q[i], cdb_tag, cdb_val);
      end
      if (accept && (wr_idx == CW'(i))) begin
        ent_d[i] = disp_woken;
      end
    end
  end

  // Occupancy: flush empties the queue outright.
  always_comb begin
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(accept) - CW'(issue);
    end
  end

  // Entry payload storage; validity comes from count, so no reset is needed here.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_q[i] <= ent_d[i];
    end
  end

  // Control state and the registered issue packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      en_q     <= 1'b0;
      rs2exe_q <= '0;
    end else begin
      count_q <= count_d;
      en_q    <= issue;
      if (issue) begin
        rs2exe_q <= issue_pkt;
      end
    end
  end

  assign en     = en_q;
  assign rs2exe = rs2exe_q;

endmodule

// File: tb/tb_rs_branch.sv
// tb_rs_branch: directed scenarios plus random traffic for rs_branch, checked
// against a queue-based reference model of the reservation station.
module tb_rs_branch;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         dispatch_valid;
  logic         dispatch_ready;
  logic [9:0]   dispatch_inst;
  logic [5:0]   dispatch_dest;
  logic [5:0]   dispatch_tag1;
  logic [5:0]   dispatch_tag2;
  logic [31:0]  dispatch_opr1;
  logic [31:0]  dispatch_opr2;
  logic [31:0]  dispatch_addr;
  logic [37:0]  cdb;
  logic         en;
  logic [111:0] rs2exe;

  rs_branch #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .dispatch_valid (dispatch_valid),
    .dispatch_ready (dispatch_ready),
    .dispatch_inst  (dispatch_inst),
    .dispatch_dest  (dispatch_dest),
    .dispatch_tag1  (dispatch_tag1),
    .dispatch_tag2  (dispatch_tag2),
    .dispatch_opr1  (dispatch_opr1),
    .dispatch_opr2  (dispatch_opr2),
    .dispatch_addr  (dispatch_addr),
    .cdb            (cdb),
    .en             (en),
    .rs2exe         (rs2exe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  inst;
    logic [5:0]  dest;
    logic [5:0]  tag1;
    logic [31:0] opr1;
    logic [5:0]  tag2;
    logic [31:0] opr2;
    logic [31:0] addr;
  } ent_t;

  ent_t         mq[$];
  bit           en_m = 1'b0;
  logic [111:0] pkt_m = '0;
  logic [5:0]   issued_dest[$];
  logic [5:0]   exp_order [4] = '{6'd2, 6'd3, 6'd4, 6'd1};
  int           total = 0;
  int           bad = 0;
  int           r;
  logic [6:0]   cls;

  task automatic check_eq(input string tag, input logic [111:0] got, input logic [111:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ent_t wake(input ent_t e, input logic [37:0] c);
    ent_t o;
    o = e;
    if (c[37:32] != 6'd0 && o.tag1 == c[37:32]) begin o.tag1 = 6'd0; o.opr1 = c[31:0]; end
    if (c[37:32] != 6'd0 && o.tag2 == c[37:32]) begin o.tag2 = 6'd0; o.opr2 = c[31:0]; end
    return o;
  endfunction

  // Reference behaviour of one clock edge, from the current TB-driven inputs.
  task automatic model_edge();
    int   s;
    bit   acc;
    ent_t n;
    s = -1;
    if (flush) begin
      mq.delete();
      en_m = 1'b0;
    end else begin
      acc = dispatch_valid && (mq.size() < DEPTH);
      for (int i = 0; i < mq.size(); i++)
        if (s < 0 && mq[i].tag1 == 6'd0 && mq[i].tag2 == 6'd0) s = i;
      if (s >= 0) begin
        en_m  = 1'b1;
        pkt_m = {mq[s].inst, mq[s].dest, mq[s].opr1, mq[s].opr2, mq[s].addr};
        mq.delete(s);
      end else begin
        en_m = 1'b0;
      end
      for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i], cdb);
      if (acc) begin
        n.inst = dispatch_inst; n.dest = dispatch_dest;
        n.tag1 = dispatch_tag1; n.opr1 = dispatch_opr1;
        n.tag2 = dispatch_tag2; n.opr2 = dispatch_opr2;
        n.addr = dispatch_addr;
        mq.push_back(wake(n, cdb));
      end
    end
  endtask

  task automatic drive(input bit v, input logic [9:0] inst, input logic [5:0] dest,
                       input logic [5:0] t1, input logic [5:0] t2, input logic [31:0] o1,
                       input logic [31:0] o2, input logic [31:0] a, input logic [37:0] c,
                       input bit f);
    dispatch_valid = v; dispatch_inst = inst; dispatch_dest = dest;
    dispatch_tag1 = t1; dispatch_tag2 = t2; dispatch_opr1 = o1;
    dispatch_opr2 = o2; dispatch_addr = a; cdb = c; flush = f;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  // One cycle: inputs already driven at the preceding negedge.
  task automatic step();
    #1;
    check_eq("dispatch_ready", 112'(dispatch_ready), 112'((mq.size() < DEPTH) && !flush));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("en", 112'(en), 112'(en_m));
    if (en_m) begin
      check_eq("rs2exe", rs2exe, pkt_m);
      $display("issue inst=%h dest=%0d opr1=%h opr2=%h addr=%h",
               rs2exe[111:102], rs2exe[101:96], rs2exe[95:64], rs2exe[63:32], rs2exe[31:0]);
    end
    if (en) issued_dest.push_back(rs2exe[101:96]);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    check_eq("reset_en", 112'(en), 112'(0));
    check_eq("reset_pkt", rs2exe, 112'(0));
    check_eq("reset_ready", 112'(dispatch_ready), 112'(1));
    rst = 1'b0;

    // Ready BEQ: two cycles dispatch-to-issue.
    drive(1'b1, 10'h000, 6'd0, 6'd0, 6'd0, 32'd5, 32'd5, 32'h100, '0, 1'b0);
    step();
    check_eq("beq_not_yet", 112'(en), 112'(0));
    idle();
    step();
    check_eq("beq_en", 112'(en), 112'(1));
    check_eq("beq_pkt", rs2exe, {10'h000, 6'd0, 32'd5, 32'd5, 32'h100});
    step();
    check_eq("beq_one_cycle", 112'(en), 112'(0));

    // JALR waiting on tag 12, broadcast two cycles after dispatch.
    drive(1'b1, 10'h200, 6'd7, 6'd12, 6'd0, 32'hDEAD, 32'd4, 32'h44, '0, 1'b0);
    step();
    idle();
    step();
    check_eq("wake_early0", 112'(en), 112'(0));
    cdb = {6'd12, 32'h1000};
    step();
    check_eq("wake_early1", 112'(en), 112'(0));
    idle();
    step();
    check_eq("wake_en", 112'(en), 112'(1));
    check_eq("wake_pkt", rs2exe, {10'h200, 6'd7, 32'h1000, 32'd4, 32'h44});
    step();

    // Same-cycle broadcast bypasses into the dispatched entry.
    drive(1'b1, 10'h100, 6'd3, 6'd9, 6'd9, 32'h1111, 32'h2222, 32'h8, {6'd9, 32'hCAFE}, 1'b0);
    step();
    idle();
    step();
    check_eq("bypass_en", 112'(en), 112'(1));
    check_eq("bypass_pkt", rs2exe, {10'h100, 6'd3, 32'hCAFE, 32'hCAFE, 32'h8});
    step();

    // Full queue, oldest waiting on tag 3, younger ones released together.
    issued_dest.delete();
    drive(1'b1, 10'h003, 6'd1, 6'd3, 6'd0, '0, 32'd1, 32'h10, '0, 1'b0);
    step();
    for (int k = 2; k <= 4; k++) begin
      drive(1'b1, 10'h001, 6'(k), 6'd20, 6'd20, 32'(k), 32'(k), 32'h10 + 32'(k), '0, 1'b0);
      step();
    end
    drive(1'b1, 10'h002, 6'd9, 6'd0, 6'd0, 32'd9, 32'd9, 32'h90, {6'd20, 32'h77}, 1'b0);
    #1 check_eq("full_ready0", 112'(dispatch_ready), 112'(0));
    step();
    drive(1'b1, 10'h002, 6'd9, 6'd0, 6'd0, 32'd9, 32'd9, 32'h90, '0, 1'b0);
    #1 check_eq("full_ready1", 112'(dispatch_ready), 112'(0));
    step();
    idle();
    #1 check_eq("full_ready_back", 112'(dispatch_ready), 112'(1));
    step();
    cdb = {6'd3, 32'h333};
    step();
    idle();
    repeat (3) step();
    check_eq("order_count", 112'(issued_dest.size()), 112'(4));
    for (int k = 0; k < 4 && k < issued_dest.size(); k++)
      check_eq("order", 112'(issued_dest[k]), 112'(exp_order[k]));

    // Flush with three ready entries and a coinciding dispatch.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 10'h004, 6'(10 + k), 6'd30, 6'd0, '0, 32'(k), 32'h200 + 32'(k), '0, 1'b0);
      step();
    end
    idle();
    cdb = {6'd30, 32'h5};
    step();
    drive(1'b1, 10'h005, 6'd40, 6'd0, 6'd0, 32'd1, 32'd2, 32'h300, '0, 1'b1);
    #1 check_eq("flush_ready", 112'(dispatch_ready), 112'(0));
    step();
    check_eq("flush_en", 112'(en), 112'(0));
    idle();
    repeat (3) begin
      step();
      check_eq("flush_quiet", 112'(en), 112'(0));
    end
    drive(1'b1, 10'h006, 6'd41, 6'd0, 6'd0, 32'h12, 32'h34, 32'h400, '0, 1'b0);
    step();
    idle();
    step();
    check_eq("post_flush_en", 112'(en), 112'(1));
    check_eq("post_flush_pkt", rs2exe, {10'h006, 6'd41, 32'h12, 32'h34, 32'h400});
    step();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 2));
      cls = (r == 0) ? 7'h40 : ((r == 1) ? 7'h20 : 7'h00);
      drive($urandom_range(0, 9) < 7, {cls, 3'($urandom_range(0, 7))}, 6'($urandom_range(0, 63)),
            ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(1, 7)),
            ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(1, 7)),
            $urandom, $urandom, $urandom,
            {6'($urandom_range(0, 7)), 32'($urandom)}, $urandom_range(0, 29) == 0);
      step();
    end
    drive(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b1);
    step();

    // Asynchronous reset while three entries are held and one is issuing.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 10'h007, 6'(50 + k), 6'd50, 6'd0, '0, 32'(k), 32'h500, '0, 1'b0);
      step();
    end
    drive(1'b1, 10'h008, 6'd60, 6'd0, 6'd0, 32'hA, 32'hB, 32'hC, '0, 1'b0);
    step();
    idle();
    step();
    check_eq("pre_rst_en", 112'(en), 112'(1));
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_en", 112'(en), 112'(0));
    check_eq("rst_async_pkt", rs2exe, 112'(0));
    check_eq("rst_async_ready", 112'(dispatch_ready), 112'(1));
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    en_m = 1'b0;
    cdb = {6'd50, 32'h9};
    step();
    check_eq("post_rst_quiet", 112'(en), 112'(0));
    idle();
    repeat (3) begin
      step();
      check_eq("post_rst_quiet", 112'(en), 112'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
